instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 43 ++++
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/instruction_fetch_unit_program_counter.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
// Holds the default widths, the fetch FSM state encoding, and the opcode and
// ALU-op codes that the control unit decodes from the IR opcode field.
package instruction_fetch_unit_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W_DEF   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    typedef enum logic [OPC_W_DEF-1:0] {
        OPC_NOP = 6'h00,
        OPC_LD  = 6'h01,
        OPC_ST  = 6'h02,
        OPC_ADD = 6'h03,
        OPC_SUB = 6'h04,
        OPC_AND = 6'h05,
        OPC_OR  = 6'h06,
        OPC_MUL = 6'h07,
        OPC_DIV = 6'h08,
        OPC_JMP = 6'h10,
        OPC_BEQ = 6'h11,
        OPC_BNE = 6'h12,
        OPC_HLT = 6'h3F
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_MUL  = 3'd5,
        ALU_DIV  = 3'd6
    } alu_op_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus.
//   imem_req  : read request (fetch unit -> memory)
//   imem_addr : read address (fetch unit -> memory)
//   imem_ack  : memory acknowledge, imem_data valid in the same cycle
//   imem_data : instruction word (memory -> fetch unit)
// master = fetch unit side, slave = memory side.
interface instruction_fetch_unit_if
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register with incrementer and branch mux.
//   clk, rst   : clock, asynchronous active-low reset
//   advance    : update pc this cycle (end of an instruction)
//   take_bra   : on advance, load bra_target instead of pc+1
//   bra_target : branch destination
//   pc         : current program counter
module program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            take_bra,
    input  logic [PC_W-1:0] bra_target,
    output logic [PC_W-1:0] pc
);
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_inc;

    // Natural width truncation gives the modulo-2^PC_W wrap.
    assign pc_inc = pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else if (advance) begin
            pc_q <= take_bra ? bra_target : pc_inc;
        end
    end

    assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequences fetch / execute for a simple in-order core.
//   clk, rst    : clock, asynchronous active-low reset
//   imem        : instruction memory read bus (master side)
//   opcode      : IR opcode field to the control unit
//   operand     : IR low field (register / immediate / target)
//   ir_valid    : IR holds an instruction in execute
//   pc          : address of the instruction in IR
//   bra, hlt    : branch taken / halt from the control unit
//   bra_target  : branch destination from the datapath
//   exec_busy   : datapath needs more execute cycles
//   halted      : processor stopped by HLT
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | just out of reset, moves to fetch on the next edge
// ST_FETCH | imem_req high with imem_addr=pc, waiting for imem_ack
// ST_EXEC  | IR valid; leave when exec_busy drops (hlt > bra > pc+1)
// ST_HALT  | stopped; only reset leaves this state
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int OPC_W   = OPC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master imem,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] operand,
    output logic                     ir_valid,
    output logic [PC_W-1:0]          pc,
    input  logic                     bra,
    input  logic                     hlt,
    input  logic [PC_W-1:0]          bra_target,
    input  logic                     exec_busy,
    output logic                     halted
);
    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_load;
    logic               pc_advance;
    logic               pc_take_bra;
    logic               fetching;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_load     = 1'b0;
        pc_advance  = 1'b0;
        pc_take_bra = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!exec_busy) begin
                    if (hlt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_advance  = 1'b1;
                        pc_take_bra = bra;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The ack is only honoured while fetching, so stray acks elsewhere
    // (including one pending across a reset) never touch IR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= imem.imem_data;
        end
    end

    program_counter #(
        .PC_W (PC_W)
    ) u_program_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (pc_advance),
        .take_bra   (pc_take_bra),
        .bra_target (bra_target),
        .pc         (pc)
    );

    // Request and address come straight from the state register so reset
    // drops them combinationally, mid-fetch included.
    assign fetching       = (state_q == ST_FETCH);
    assign imem.imem_req  = fetching;
    assign imem.imem_addr = fetching ? pc : '0;

    assign ir_valid = (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALT);
    assign opcode   = ir_q[INSTR_W-1 -: OPC_W];
    assign operand  = ir_q[INSTR_W-OPC_W-1:0];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 6;

    logic                     clk;
    logic                     rst;
    logic [OPC_W-1:0]         opcode;
    logic [INSTR_W-OPC_W-1:0] operand;
    logic                     ir_valid;
    logic [PC_W-1:0]          pc;
    logic                     bra;
    logic                     hlt;
    logic [PC_W-1:0]          bra_target;
    logic                     exec_busy;
    logic                     halted;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch_unit #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .opcode     (opcode),
        .operand    (operand),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .bra        (bra),
        .hlt        (hlt),
        .bra_target (bra_target),
        .exec_busy  (exec_busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        bra           = 1'b0;
        hlt           = 1'b0;
        bra_target    = '0;
        exec_busy     = 1'b0;

        // Reset state
        #3;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        chk("idle_req", 32'(bus.imem_req), 32'h0);

        // Back-to-back fetches with immediate ack
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'h0A11;
        tick();
        chk("f0_req", 32'(bus.imem_req), 32'h1);
        chk("f0_addr", 32'(bus.imem_addr), 32'h0);
        chk("f0_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("e0_valid", 32'(ir_valid), 32'h1);
        chk("e0_req", 32'(bus.imem_req), 32'h0);
        chk("e0_opcode", 32'(opcode), 32'h02);
        chk("e0_operand", 32'(operand), 32'h211);
        chk("e0_pc", 32'(pc), 32'h0);
        bus.imem_data = 16'h1422;
        tick();
        chk("f1_addr", 32'(bus.imem_addr), 32'h1);
        chk("f1_valid", 32'(ir_valid), 32'h0);
        tick();
        chk("e1_opcode", 32'(opcode), 32'h05);
        chk("e1_operand", 32'(operand), 32'h022);
        bus.imem_data = 16'h2833;
        tick();
        chk("f2_addr", 32'(bus.imem_addr), 32'h2);
        tick();
        bus.imem_data = 16'h3C44;
        tick();
        chk("f3_addr", 32'(bus.imem_addr), 32'h3);
        tick();
        bus.imem_data = 16'h5055;
        tick();
        chk("f4_addr", 32'(bus.imem_addr), 32'h4);
        tick();
        chk("e4_pc", 32'(pc), 32'h4);

        // Ack delayed three cycles at address 5
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'hFFFF;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wait5_req", 32'(bus.imem_req), 32'h1);
            chk("wait5_addr", 32'(bus.imem_addr), 32'h5);
            chk("wait5_ir", 32'(opcode), 32'h14);
            tick();
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'h6066;
        chk("ack5_req", 32'(bus.imem_req), 32'h1);
        chk("ack5_addr", 32'(bus.imem_addr), 32'h5);
        chk("ack5_ir_old", 32'(opcode), 32'h14);
        tick();
        chk("e5_valid", 32'(ir_valid), 32'h1);
        chk("e5_opcode", 32'(opcode), 32'h18);
        chk("e5_operand", 32'(operand), 32'h066);
        chk("e5_pc", 32'(pc), 32'h5);

        // Ack during EXEC must not reload IR
        exec_busy     = 1'b1;
        bus.imem_data = 16'hABCD;
        tick();
        chk("e5_busy_valid", 32'(ir_valid), 32'h1);
        chk("e5_ack_ignored", 32'(opcode), 32'h18);
        chk("e5_busy_pc", 32'(pc), 32'h5);
        exec_busy     = 1'b0;
        bus.imem_data = 16'h7077;
        tick();
        chk("f6_addr", 32'(bus.imem_addr), 32'h6);
        tick();
        bus.imem_data = 16'h8088;
        tick();
        tick();
        chk("e7_pc", 32'(pc), 32'h7);

        // Branch at pc=7
        bra        = 1'b1;
        bra_target = 10'h120;
        tick();
        chk("bra_addr", 32'(bus.imem_addr), 32'h120);
        chk("bra_req", 32'(bus.imem_req), 32'h1);
        bra           = 1'b0;
        bus.imem_data = 16'h0123;
        tick();
        chk("e120_pc", 32'(pc), 32'h120);

        // exec_busy at pc=0x3FF, then wrap
        bra        = 1'b1;
        bra_target = 10'h3FF;
        tick();
        chk("f3ff_addr", 32'(bus.imem_addr), 32'h3FF);
        bra           = 1'b0;
        bus.imem_data = 16'h9099;
        tick();
        exec_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("busy_valid", 32'(ir_valid), 32'h1);
            chk("busy_pc", 32'(pc), 32'h3FF);
            tick();
        end
        exec_busy = 1'b0;
        chk("busy_last_valid", 32'(ir_valid), 32'h1);
        chk("busy_opcode", 32'(opcode), 32'h24);
        tick();
        chk("wrap_addr", 32'(bus.imem_addr), 32'h0);
        chk("wrap_req", 32'(bus.imem_req), 32'h1);
        chk("wrap_valid", 32'(ir_valid), 32'h0);
        bus.imem_data = 16'hA0AA;
        tick();
        chk("e0b_opcode", 32'(opcode), 32'h28);

        // hlt and bra together: halt wins
        hlt        = 1'b1;
        bra        = 1'b1;
        bra_target = 10'h055;
        tick();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_req", 32'(bus.imem_req), 32'h0);
        chk("halt_pc", 32'(pc), 32'h0);
        chk("halt_valid", 32'(ir_valid), 32'h0);
        hlt = 1'b0;
        bra = 1'b0;
        tick();
        tick();
        tick();
        chk("halt_stay", 32'(halted), 32'h1);
        chk("halt_stay_req", 32'(bus.imem_req), 32'h0);
        chk("halt_stay_pc", 32'(pc), 32'h0);

        // Reset leaves HALT
        rst = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("restart_addr", 32'(bus.imem_addr), 32'h0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'hB0BB;
        tick();
        chk("restart_opcode", 32'(opcode), 32'h2C);

        // Reset during pending fetch at address 9
        bra          = 1'b1;
        bra_target   = 10'h009;
        bus.imem_ack = 1'b0;
        tick();
        bra = 1'b0;
        chk("f9_req", 32'(bus.imem_req), 32'h1);
        chk("f9_addr", 32'(bus.imem_addr), 32'h9);
        tick();
        #2;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'hC0CC;
        rst           = 1'b0;
        #1;
        chk("midrst_req", 32'(bus.imem_req), 32'h0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'h0);
        chk("midrst_pc", 32'(pc), 32'h0);
        chk("midrst_opcode", 32'(opcode), 32'h0);
        tick();
        rst = 1'b1;
        chk("post_rst_req", 32'(bus.imem_req), 32'h0);
        chk("post_rst_valid", 32'(ir_valid), 32'h0);
        chk("post_rst_opcode", 32'(opcode), 32'h0);
        tick();
        chk("post_rst_fetch_req", 32'(bus.imem_req), 32'h1);
        chk("post_rst_fetch_addr", 32'(bus.imem_addr), 32'h0);
        tick();
        chk("post_rst_exec_valid", 32'(ir_valid), 32'h1);
        chk("post_rst_exec_opcode", 32'(opcode), 32'h30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
